// File: rtl/pifo_pkg.sv
// Shared types and constants for the PIFO front-end controller.
package pifo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2
  } deq_state_e;

  localparam int unsigned STATS_CNT_WIDTH = 32;

endpackage

// File: rtl/pifo_io_ctrl_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned PW = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(ptr) + k) % NUM_PORTS;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/pifo_io_ctrl.sv
// PIFO front end: round-robin insert arbitration, occupancy tracking and a
// one-entry dequeue register. Define PIFO_IO_CTRL_STATS_EN for event counters.
module pifo_io_ctrl
  import pifo_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned RANK_WIDTH  = 10,
  parameter int unsigned META_WIDTH  = 20,
  parameter int unsigned L2_MAX_SIZE = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             enq_valid,
  input  logic [NUM_PORTS*RANK_WIDTH-1:0]  enq_rank,
  input  logic [NUM_PORTS*META_WIDTH-1:0]  enq_meta,
  output logic [NUM_PORTS-1:0]             enq_ready,
  output logic                             deq_valid,
  input  logic                             deq_ready,
  output logic [RANK_WIDTH-1:0]            deq_rank,
  output logic [META_WIDTH-1:0]            deq_meta,
  output logic                             pifo_insert,
  output logic                             pifo_remove,
  output logic [RANK_WIDTH-1:0]            pifo_rank_in,
  output logic [META_WIDTH-1:0]            pifo_meta_in,
  input  logic [RANK_WIDTH-1:0]            pifo_rank_out,
  input  logic [META_WIDTH-1:0]            pifo_meta_out,
  input  logic                             pifo_valid_out,
  input  logic                             pifo_busy,
  input  logic                             pifo_full,
`ifdef PIFO_IO_CTRL_STATS_EN
  output logic [STATS_CNT_WIDTH-1:0]       enq_cnt,
  output logic [STATS_CNT_WIDTH-1:0]       deq_cnt,
  output logic [STATS_CNT_WIDTH-1:0]       blocked_cnt,
`endif
  output logic [L2_MAX_SIZE:0]             occupancy
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam logic [L2_MAX_SIZE:0] CAPACITY = {1'b1, {L2_MAX_SIZE{1'b0}}};

  deq_state_e           state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        grant_idx;
  logic [NUM_PORTS-1:0] grant;
  logic                 eligible;

  // Gating with rst_n keeps grants off while reset is held.
  assign eligible = rst_n & ~pifo_busy & ~pifo_full & (occupancy != CAPACITY);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req       (enq_valid),
    .en        (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign enq_ready   = grant;
  assign pifo_insert = |grant;
  assign pifo_remove = (state == EMPTY) & pifo_valid_out & (occupancy != '0);

  always_comb begin
    pifo_rank_in = '0;
    pifo_meta_in = '0;
    if (pifo_insert) begin
      pifo_rank_in = enq_rank[grant_idx*RANK_WIDTH +: RANK_WIDTH];
      pifo_meta_in = enq_meta[grant_idx*META_WIDTH +: META_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (pifo_insert) begin
      rr_ptr <= (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (pifo_insert && !pifo_remove) begin
      occupancy <= occupancy + 1'b1;
    end else if (!pifo_insert && pifo_remove) begin
      occupancy <= occupancy - 1'b1;
    end
  end

  // SETTLE gives the PIFO one idle cycle to refresh its registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      deq_valid <= 1'b0;
      deq_rank  <= '0;
      deq_meta  <= '0;
    end else begin
      case (state)
        EMPTY: if (pifo_remove) begin
          deq_rank  <= pifo_rank_out;
          deq_meta  <= pifo_meta_out;
          deq_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (deq_ready) begin
          deq_valid <= 1'b0;
          state     <= SETTLE;
        end
        SETTLE: state <= EMPTY;
        default: begin
          deq_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIFO_IO_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq_cnt     <= '0;
      deq_cnt     <= '0;
      blocked_cnt <= '0;
    end else begin
      if (pifo_insert && enq_cnt != '1) enq_cnt <= enq_cnt + 1'b1;
      if (deq_valid && deq_ready && deq_cnt != '1) deq_cnt <= deq_cnt + 1'b1;
      if (|enq_valid && !pifo_insert && blocked_cnt != '1) blocked_cnt <= blocked_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pifo_io_ctrl.sv
// Self-checking bench for pifo_io_ctrl with a behavioural PIFO model.
module tb_pifo_io_ctrl;

  localparam int N  = 4;
  localparam int RW = 10;
  localparam int MW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  enq_valid;
  logic [N*RW-1:0] enq_rank;
  logic [N*MW-1:0] enq_meta;
  logic [N-1:0]  enq_ready;
  logic          deq_valid, deq_ready;
  logic [RW-1:0] deq_rank;
  logic [MW-1:0] deq_meta;
  logic          pifo_insert, pifo_remove;
  logic [RW-1:0] pifo_rank_in, pifo_rank_out;
  logic [MW-1:0] pifo_meta_in, pifo_meta_out;
  logic          pifo_valid_out, pifo_busy, pifo_full;
  logic [5:0]    occupancy;
`ifdef PIFO_IO_CTRL_STATS_EN
  logic [31:0]   enq_cnt, deq_cnt, blocked_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pifo_io_ctrl #(.NUM_PORTS(N), .RANK_WIDTH(RW), .META_WIDTH(MW), .L2_MAX_SIZE(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_rank(enq_rank), .enq_meta(enq_meta), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_rank(deq_rank), .deq_meta(deq_meta),
    .pifo_insert(pifo_insert), .pifo_remove(pifo_remove),
    .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
    .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
    .pifo_valid_out(pifo_valid_out), .pifo_busy(pifo_busy), .pifo_full(pifo_full),
`ifdef PIFO_IO_CTRL_STATS_EN
    .enq_cnt(enq_cnt), .deq_cnt(deq_cnt), .blocked_cnt(blocked_cnt),
`endif
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // PIFO model: unordered store, head = smallest rank (oldest on ties).
  logic [29:0] m_q [64];
  int          m_cnt;
  int          head_idx;
  logic        vo_en;
  logic [29:0] exp_deq [$];
  logic [RW-1:0] obs [$];

  always_comb begin
    head_idx = 0;
    for (int i = 1; i < 64; i++)
      if (i < m_cnt && m_q[i][29:20] < m_q[head_idx][29:20]) head_idx = i;
  end

  assign pifo_valid_out = vo_en & (m_cnt != 0);
  assign pifo_rank_out  = m_q[head_idx][29:20];
  assign pifo_meta_out  = m_q[head_idx][19:0];

  always @(posedge clk or negedge rst_n) begin
    logic [29:0] t [64];
    int c;
    if (!rst_n) begin
      m_cnt <= 0;
      exp_deq.delete();
    end else begin
      t = m_q;
      c = m_cnt;
      if (pifo_remove) begin
        exp_deq.push_back(t[head_idx]);
        for (int i = 0; i < 63; i++) if (i >= head_idx) t[i] = t[i+1];
        c--;
      end
      if (pifo_insert) begin
        t[c] = {pifo_rank_in, pifo_meta_in};
        c++;
      end
      m_q   <= t;
      m_cnt <= c;
    end
  end

  int cyc = 0;
  int last_rem = -1;
  int rem_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_rem = -1;
    end else begin
      chk("occupancy_vs_model", 64'(occupancy), 64'(m_cnt));
      if (pifo_remove) begin
        if (last_rem >= 0) chk("remove_gap_ge3", 64'(cyc - last_rem >= 3), 64'd1);
        last_rem = cyc;
        rem_cnt++;
      end
      if (deq_valid && deq_ready) begin
        chk("deq_has_expected", 64'(exp_deq.size() != 0), 64'd1);
        if (exp_deq.size() != 0) begin
          logic [29:0] e;
          e = exp_deq.pop_front();
          chk("deq_rank", 64'(deq_rank), 64'(e[29:20]));
          chk("deq_meta", 64'(deq_meta), 64'(e[19:0]));
          obs.push_back(deq_rank);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] v;
    logic       busy;
    logic       full;
    logic [3:0] ready;
    logic [5:0] occ;
  } vec_t;
  vec_t tbl [16];

  task automatic do_reset();
    rst_n = 1'b0; enq_valid = '0; vo_en = 1'b0; deq_ready = 1'b0;
    pifo_busy = 1'b0; pifo_full = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rem_base, ref_ptr, gp;
    logic [3:0] exp_g;
    logic [RW-1:0] er;
    logic [MW-1:0] em;

    rst_n = 1'b0; vo_en = 1'b0; deq_ready = 1'b0; pifo_busy = 1'b0; pifo_full = 1'b0;
    enq_valid = 4'b1111;
    for (int p = 0; p < N; p++) begin
      enq_rank[p*RW +: RW] = RW'(10 + p);
      enq_meta[p*MW +: MW] = MW'(100 + p);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_enq_ready", 64'(enq_ready), 64'd0);
    chk("rst_insert", 64'(pifo_insert), 64'd0);
    chk("rst_remove", 64'(pifo_remove), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_rank", 64'(deq_rank), 64'd0);
    chk("rst_deq_meta", 64'(deq_meta), 64'd0);
    chk("rst_rank_in", 64'(pifo_rank_in), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tbl[0]  = '{4'b1111, 0, 0, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 0, 0, 4'b0010, 1};
    tbl[2]  = '{4'b1111, 0, 0, 4'b0100, 2};
    tbl[3]  = '{4'b1111, 0, 0, 4'b1000, 3};
    tbl[4]  = '{4'b1111, 0, 0, 4'b0001, 4};
    tbl[5]  = '{4'b0010, 0, 0, 4'b0010, 5};
    tbl[6]  = '{4'b1010, 0, 0, 4'b1000, 6};
    tbl[7]  = '{4'b1010, 0, 0, 4'b0010, 7};
    tbl[8]  = '{4'b1111, 1, 0, 4'b0000, 8};
    tbl[9]  = '{4'b1111, 1, 0, 4'b0000, 8};
    tbl[10] = '{4'b1111, 0, 1, 4'b0000, 8};
    tbl[11] = '{4'b0000, 0, 0, 4'b0000, 8};
    tbl[12] = '{4'b1111, 0, 0, 4'b0100, 8};
    tbl[13] = '{4'b0001, 0, 0, 4'b0001, 9};
    tbl[14] = '{4'b0001, 0, 0, 4'b0001, 10};
    tbl[15] = '{4'b0100, 0, 0, 4'b0100, 11};

    for (int i = 0; i < 16; i++) begin
      enq_valid = tbl[i].v; pifo_busy = tbl[i].busy; pifo_full = tbl[i].full;
      @(negedge clk);
      er = '0; em = '0;
      for (int p = 0; p < N; p++)
        if (tbl[i].ready[p]) begin er = RW'(10 + p); em = MW'(100 + p); end
      chk("tbl_enq_ready", 64'(enq_ready), 64'(tbl[i].ready));
      chk("tbl_insert", 64'(pifo_insert), 64'(|tbl[i].ready));
      chk("tbl_rank_in", 64'(pifo_rank_in), 64'(er));
      chk("tbl_meta_in", 64'(pifo_meta_in), 64'(em));
      chk("tbl_occ", 64'(occupancy), 64'(tbl[i].occ));
      @(posedge clk); #1;
    end
    enq_valid = '0; pifo_busy = 1'b0; pifo_full = 1'b0;

    // Ranks 7,3,5 must drain in priority order
    do_reset();
    enq_valid = 4'b0001;
    enq_rank[9:0] = 10'd7; @(posedge clk); #1;
    enq_rank[9:0] = 10'd3; @(posedge clk); #1;
    enq_rank[9:0] = 10'd5; @(posedge clk); #1;
    enq_valid = '0;
    obs.delete();
    rem_base = rem_cnt;
    vo_en = 1'b1; deq_ready = 1'b1;
    for (int k = 0; k < 40 && obs.size() < 3; k++) @(negedge clk);
    chk("prio_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      chk("prio_first", 64'(obs[0]), 64'd3);
      chk("prio_second", 64'(obs[1]), 64'd5);
      chk("prio_third", 64'(obs[2]), 64'd7);
    end
    repeat (3) @(negedge clk);
    chk("prio_removes", 64'(rem_cnt - rem_base), 64'd3);
    chk("prio_occ_zero", 64'(occupancy), 64'd0);

    // Latency, HOLD stability and SETTLE gap
    @(posedge clk); #1;
    deq_ready = 1'b0;
    enq_valid = 4'b0100;
    enq_rank[2*RW +: RW] = 10'd40; enq_meta[2*MW +: MW] = 20'd77;
    @(posedge clk); #1;
    enq_valid = 4'b0010;
    enq_rank[1*RW +: RW] = 10'd50; enq_meta[1*MW +: MW] = 20'd88;
    @(negedge clk);
    chk("lat_remove_now", 64'(pifo_remove), 64'd1);
    chk("lat_not_valid_yet", 64'(deq_valid), 64'd0);
    @(posedge clk); #1;
    enq_valid = '0;
    rem_base = rem_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(deq_valid), 64'd1);
      chk("hold_rank", 64'(deq_rank), 64'd40);
      chk("hold_meta", 64'(deq_meta), 64'd77);
      @(posedge clk); #1;
    end
    chk("hold_no_remove", 64'(rem_cnt - rem_base), 64'd0);
    deq_ready = 1'b1;
    @(posedge clk); #1;
    deq_ready = 1'b0;
    @(negedge clk);
    chk("settle_no_remove", 64'(pifo_remove), 64'd0);
    chk("settle_not_valid", 64'(deq_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("next_remove_t3", 64'(pifo_remove), 64'd1);
    @(posedge clk); #1;
    deq_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Capacity boundary
    do_reset();
    enq_valid = 4'b0001;
    repeat (31) begin
      enq_rank[9:0] = RW'($urandom);
      @(posedge clk); #1;
    end
    vo_en = 1'b1;
    @(negedge clk);
    chk("cap31_occ", 64'(occupancy), 64'd31);
    chk("cap31_insert", 64'(pifo_insert), 64'd1);
    chk("cap31_remove", 64'(pifo_remove), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cap31_both_occ", 64'(occupancy), 64'd31);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cap32_occ", 64'(occupancy), 64'd32);
    chk("cap32_enq_ready", 64'(enq_ready), 64'd0);
    chk("cap32_insert", 64'(pifo_insert), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic against the reference
    do_reset();
    vo_en = 1'b1;
    ref_ptr = 0;
    for (int c = 0; c < 2000; c++) begin
      enq_valid = N'($urandom);
      for (int p = 0; p < N; p++) begin
        enq_rank[p*RW +: RW] = RW'($urandom);
        enq_meta[p*MW +: MW] = MW'($urandom);
      end
      pifo_busy = ($urandom % 5) == 0;
      pifo_full = ($urandom % 20) == 0;
      deq_ready = $urandom % 2;
      @(negedge clk);
      exp_g = '0; gp = -1;
      if (!pifo_busy && !pifo_full && m_cnt < 32)
        for (int k = 0; k < N; k++)
          if (gp < 0 && enq_valid[(ref_ptr + k) % N]) gp = (ref_ptr + k) % N;
      if (gp >= 0) exp_g[gp] = 1'b1;
      chk("rnd_enq_ready", 64'(enq_ready), 64'(exp_g));
      chk("rnd_rank_in", 64'(pifo_rank_in), gp >= 0 ? 64'(enq_rank[gp*RW +: RW]) : 64'd0);
      chk("rnd_meta_in", 64'(pifo_meta_in), gp >= 0 ? 64'(enq_meta[gp*MW +: MW]) : 64'd0);
      if (gp >= 0) ref_ptr = (gp + 1) % N;
      @(posedge clk); #1;
    end
    enq_valid = '0; pifo_busy = 1'b0; pifo_full = 1'b0; deq_ready = 1'b1;
    repeat (150) @(posedge clk);
    @(negedge clk);
    chk("drain_occ", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
